rom_access_arbiter: RTL and testbench
=====================================

Name: rom_access_arbiter

Overview:
- Shares the single instruction ROM port (ce/addr/data, combinational read) between two requesters: the CPU fetch stage (IF) and a load port (LS) used for constant/literal reads from ROM.
- Sequences each access through a configurable number of wait states and returns the read data with a one-cycle valid pulse.
- Arbitrates with fixed LS priority plus an IF starvation guard.
- Sits in the SOPC between the CPU core and the ROM.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- WAIT_CYCLES, 1, extra ROM wait states per access (0..15).
- STARVE_MAX, 4, consecutive LS grants allowed while IF is pending (1..15).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- if_req_i  in  1  fetch request.
- if_addr_i  in  ADDR_W  fetch address.
- if_flush_i  in  1  cancel the in-flight IF result (branch redirect).
- if_ready_o  out  1  IF request accepted this cycle (combinational).
- if_data_o  out  DATA_W  fetched instruction.
- if_valid_o  out  1  if_data_o valid, single-cycle pulse.
- ls_req_i  in  1  load request.
- ls_addr_i  in  ADDR_W  load address.
- ls_ready_o  out  1  LS request accepted this cycle (combinational).
- ls_data_o  out  DATA_W  load data.
- ls_valid_o  out  1  ls_data_o valid, single-cycle pulse.
- mem_ce_o  out  1  ROM chip enable.
- mem_addr_o  out  ADDR_W  ROM address.
- mem_data_i  in  DATA_W  ROM read data.
- busy_o  out  1  arbiter in ACCESS.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, wait counter=0, starve counter=0, owner=IF. Registered outputs all 0: mem_ce_o, mem_addr_o, if/ls data, if/ls valid, busy_o. Any in-flight access is discarded; no valid pulse follows reset release.
- Request rule: a requester holds req/addr stable until its ready is high; the transfer occurs in the cycle where req && ready.
- ready_o is asserted only in IDLE, to at most one requester, the winner.
- Winner selection in IDLE:
  - LS wins if ls_req_i, unless if_req_i && starve_cnt==STARVE_MAX, in which case IF wins.
  - Otherwise IF wins if if_req_i.
- Starve counter:
  - increments on an LS grant while if_req_i=1;
  - clears on an IF grant, or in any IDLE cycle with if_req_i=0;
  - saturates at STARVE_MAX.
- FSM:
  - IDLE: on accept at cycle T, latch addr into mem_addr_o, record owner, clear wait counter, go to ACCESS. mem_ce_o=0.
  - ACCESS: occupies cycles T+1 .. T+1+WAIT_CYCLES with mem_ce_o=1, busy_o=1, counter incrementing.
  - Leaving ACCESS: when counter==WAIT_CYCLES, capture mem_data_i into the owner's data register, set the owner's valid for the next cycle, return to IDLE.
- Latency: valid high in cycle T+2+WAIT_CYCLES.
- Back-to-back: the valid cycle is an IDLE cycle, so a new accept is allowed in it. Peak rate is one access per WAIT_CYCLES+2 cycles.
- Data registers hold their value until the next capture for the same owner. Valid is exactly one cycle wide.
- mem_addr_o holds the last address after completion. mem_ce_o drops in IDLE.
- Flush:
  - if_flush_i=1 in any ACCESS cycle of an IF-owned access sets a kill flag. On completion the data is captured but if_valid_o stays 0. The kill flag clears on return to IDLE.
  - if_flush_i in the completion cycle also kills.
  - Flush in IDLE has no effect.
  - Flush never affects LS accesses.
- Simultaneous requests in IDLE: exactly one ready; the loser keeps its req asserted and is served later.
- Both valids are never high in the same cycle.

Test Plan:
- Reset then single IF (WAIT_CYCLES=1): if_req with addr 0x00000004 at cycle 0 → if_ready_o=1 at cycle 0, mem_ce_o=1 in cycles 1–2 with mem_addr_o=0x4, if_valid_o=1 only in cycle 3 with ROM word at 0x4, ls_valid_o=0 throughout.
- Simultaneous IF 0x8 and LS 0x10 → LS accepted first, ls_valid_o at cycle 3; IF accepted at cycle 3, if_valid_o at cycle 6.
- Starvation (STARVE_MAX=4, LS and IF both held high) → 4 LS grants, then 1 IF grant, then the LS sequence repeats.
- Flush: IF access to 0x20 with if_flush_i pulsed in cycle 1 → no if_valid_o; the next IF to 0x24 returns its data normally; an LS access issued alongside is unaffected.
- Reset mid-access: rst=0 in cycle 2 of an LS access → all outputs 0 immediately, no ls_valid_o after release, next request served from IDLE.
- WAIT_CYCLES=0 back-to-back IF to 0x0, 0x4, 0x8 → valids at cycles 2, 4, 6 with correct data; ready in cycles 0, 2, 4.

Source files
------------

// File: rtl/rom_access_arbiter.sv
// Two-requester arbiter (fetch and load port) for a single combinational-read ROM.
// LS has fixed priority; a starvation counter forces an IF grant after STARVE_MAX LS grants.
module rom_access_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = 1,
  parameter int STARVE_MAX  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  input  logic              if_flush_i,
  output logic              if_ready_o,
  output logic [DATA_W-1:0] if_data_o,
  output logic              if_valid_o,
  input  logic              ls_req_i,
  input  logic [ADDR_W-1:0] ls_addr_i,
  output logic              ls_ready_o,
  output logic [DATA_W-1:0] ls_data_o,
  output logic              ls_valid_o,
  output logic              mem_ce_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [DATA_W-1:0] mem_data_i,
  output logic              busy_o
);
  typedef enum logic {IDLE, ACCESS} state_t;

  localparam logic [3:0] WAIT_LIM   = 4'(WAIT_CYCLES);
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t     state, state_nxt;
  logic [3:0] wait_cnt, starve_cnt;
  logic       owner_ls;
  logic       kill;
  logic       grant_if, grant_ls, done;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    grant_if  = 1'b0;
    grant_ls  = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (ls_req_i && !(if_req_i && starve_cnt == STARVE_LIM)) grant_ls = 1'b1;
        else if (if_req_i)                                       grant_if = 1'b1;
        if (grant_if || grant_ls) state_nxt = ACCESS;
      end
      ACCESS: begin
        if (wait_cnt == WAIT_LIM) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign if_ready_o = grant_if;
  assign ls_ready_o = grant_ls;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt   <= '0;
      owner_ls   <= 1'b0;
      kill       <= 1'b0;
      mem_ce_o   <= 1'b0;
      busy_o     <= 1'b0;
      mem_addr_o <= '0;
      if_data_o  <= '0;
      ls_data_o  <= '0;
      if_valid_o <= 1'b0;
      ls_valid_o <= 1'b0;
    end else begin
      if_valid_o <= 1'b0;
      ls_valid_o <= 1'b0;
      if (grant_if || grant_ls) begin
        mem_addr_o <= grant_ls ? ls_addr_i : if_addr_i;
        owner_ls   <= grant_ls;
        wait_cnt   <= '0;
        kill       <= 1'b0;
        mem_ce_o   <= 1'b1;
        busy_o     <= 1'b1;
      end
      if (state == ACCESS) begin
        wait_cnt <= wait_cnt + 4'd1;
        if (!owner_ls && if_flush_i) kill <= 1'b1;
      end
      // Killed IF data is still captured; only the valid pulse is suppressed.
      if (done) begin
        mem_ce_o <= 1'b0;
        busy_o   <= 1'b0;
        kill     <= 1'b0;
        if (owner_ls) begin
          ls_data_o  <= mem_data_i;
          ls_valid_o <= 1'b1;
        end else begin
          if_data_o  <= mem_data_i;
          if_valid_o <= !(kill || if_flush_i);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                          starve_cnt <= '0;
    else if (grant_if)                 starve_cnt <= '0;
    else if (grant_ls && if_req_i) begin
      if (starve_cnt != STARVE_LIM)    starve_cnt <= starve_cnt + 4'd1;
    end
    else if (state == IDLE && !if_req_i) starve_cnt <= '0;
  end
endmodule

// File: tb/tb_rom_access_arbiter.sv
// Directed bench: one arbiter with one wait state, one with zero wait states, behind a
// combinational ROM model.
module tb_rom_access_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b0;

  logic        if_req, if_flush, ls_req;
  logic [31:0] if_addr, ls_addr;
  logic        if_ready, if_valid, ls_ready, ls_valid, mem_ce, busy;
  logic [31:0] if_data, ls_data, mem_addr, mem_data;

  logic        if_req0;
  logic [31:0] if_addr0;
  logic        if_ready0, if_valid0, ls_ready0, ls_valid0, mem_ce0, busy0;
  logic [31:0] if_data0, ls_data0, mem_addr0, mem_data0;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [31:0] a);
    return {~a[15:0], a[15:0]};
  endfunction

  assign mem_data  = rom(mem_addr);
  assign mem_data0 = rom(mem_addr0);

  rom_access_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(1), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_flush_i(if_flush),
    .if_ready_o(if_ready), .if_data_o(if_data), .if_valid_o(if_valid),
    .ls_req_i(ls_req), .ls_addr_i(ls_addr),
    .ls_ready_o(ls_ready), .ls_data_o(ls_data), .ls_valid_o(ls_valid),
    .mem_ce_o(mem_ce), .mem_addr_o(mem_addr), .mem_data_i(mem_data), .busy_o(busy)
  );

  rom_access_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(0), .STARVE_MAX(4)) dut0 (
    .clk(clk), .rst(rst),
    .if_req_i(if_req0), .if_addr_i(if_addr0), .if_flush_i(1'b0),
    .if_ready_o(if_ready0), .if_data_o(if_data0), .if_valid_o(if_valid0),
    .ls_req_i(1'b0), .ls_addr_i(32'h0),
    .ls_ready_o(ls_ready0), .ls_data_o(ls_data0), .ls_valid_o(ls_valid0),
    .mem_ce_o(mem_ce0), .mem_addr_o(mem_addr0), .mem_data_i(mem_data0), .busy_o(busy0)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs are driven 1ns after the rising edge and outputs sampled 1ns later.
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  initial begin
    if_req = 0; if_flush = 0; ls_req = 0; if_addr = 0; ls_addr = 0;
    if_req0 = 0; if_addr0 = 0;

    // Reset state
    repeat (3) nxt();
    #1;
    chk("rst_ce", mem_ce, 0);       chk("rst_busy", busy, 0);
    chk("rst_addr", mem_addr, 0);   chk("rst_ifd", if_data, 0);
    chk("rst_lsd", ls_data, 0);     chk("rst_ifv", if_valid, 0);
    chk("rst_lsv", ls_valid, 0);    chk("rst0_ce", mem_ce0, 0);
    rst = 1;

    // Single IF access, one wait state
    nxt(); if_req = 1; if_addr = 32'h4; #1;
    chk("if1_rdy_c0", if_ready, 1); chk("if1_lsrdy_c0", ls_ready, 0);
    chk("if1_ce_c0", mem_ce, 0);
    nxt(); if_req = 0; #1;
    chk("if1_ce_c1", mem_ce, 1);    chk("if1_addr_c1", mem_addr, 32'h4);
    chk("if1_busy_c1", busy, 1);    chk("if1_v_c1", if_valid, 0);
    nxt(); #1;
    chk("if1_ce_c2", mem_ce, 1);    chk("if1_v_c2", if_valid, 0);
    chk("if1_lsv_c2", ls_valid, 0);
    nxt(); #1;
    chk("if1_v_c3", if_valid, 1);   chk("if1_d_c3", if_data, rom(32'h4));
    chk("if1_ce_c3", mem_ce, 0);    chk("if1_lsv_c3", ls_valid, 0);
    chk("if1_addr_hold", mem_addr, 32'h4);
    nxt(); #1;
    chk("if1_v_c4", if_valid, 0);   chk("if1_d_hold", if_data, rom(32'h4));

    // Simultaneous IF and LS: LS first
    nxt(); if_req = 1; if_addr = 32'h8; ls_req = 1; ls_addr = 32'h10; #1;
    chk("sim_lsrdy_c0", ls_ready, 1); chk("sim_ifrdy_c0", if_ready, 0);
    nxt(); ls_req = 0; #1;
    chk("sim_ifrdy_c1", if_ready, 0); chk("sim_addr_c1", mem_addr, 32'h10);
    nxt(); #1;
    nxt(); #1;
    chk("sim_lsv_c3", ls_valid, 1);   chk("sim_lsd_c3", ls_data, rom(32'h10));
    chk("sim_ifrdy_c3", if_ready, 1); chk("sim_ifv_c3", if_valid, 0);
    nxt(); if_req = 0; #1;
    chk("sim_addr_c4", mem_addr, 32'h8); chk("sim_lsv_c4", ls_valid, 0);
    nxt(); #1;
    nxt(); #1;
    chk("sim_ifv_c6", if_valid, 1);   chk("sim_ifd_c6", if_data, rom(32'h8));
    chk("sim_lsv_c6", ls_valid, 0);

    // Starvation guard: 4 LS grants then 1 IF grant, repeating
    nxt(); if_req = 1; if_addr = 32'h80; ls_req = 1; ls_addr = 32'h40; #1;
    for (int g = 0; g < 10; g++) begin
      chk($sformatf("stv_ls_g%0d", g), ls_ready, (g % 5 != 4));
      chk($sformatf("stv_if_g%0d", g), if_ready, (g % 5 == 4));
      if (g > 0) begin
        chk($sformatf("stv_lsv_g%0d", g), ls_valid, ((g - 1) % 5 != 4));
        chk($sformatf("stv_ifv_g%0d", g), if_valid, ((g - 1) % 5 == 4));
      end
      if (g < 9) begin
        repeat (3) nxt();
        #1;
      end
    end
    if_req = 0; ls_req = 0;
    nxt(); #1;
    chk("stv_idle", busy, 0);

    // Flush of an IF access, then LS + IF side by side
    nxt(); if_req = 1; if_addr = 32'h20; #1;
    chk("fl_rdy_c0", if_ready, 1);
    nxt(); if_req = 0; if_flush = 1; #1;
    nxt(); if_flush = 0; #1;
    nxt(); #1;
    chk("fl_ifv_c3", if_valid, 0);    chk("fl_ifd_c3", if_data, rom(32'h20));
    if_req = 1; if_addr = 32'h24; ls_req = 1; ls_addr = 32'h30; #1;
    chk("fl_lsrdy_c3", ls_ready, 1);
    nxt(); ls_req = 0; if_flush = 1; #1;
    nxt(); if_flush = 0; #1;
    nxt(); #1;
    chk("fl_lsv_c6", ls_valid, 1);    chk("fl_lsd_c6", ls_data, rom(32'h30));
    chk("fl_ifrdy_c6", if_ready, 1);
    nxt(); if_req = 0; #1;
    nxt(); #1;
    nxt(); #1;
    chk("fl_ifv_c9", if_valid, 1);    chk("fl_ifd_c9", if_data, rom(32'h24));
    // Flush arriving in the completion cycle
    if_req = 1; if_addr = 32'h28; #1;
    chk("fl2_rdy", if_ready, 1);
    nxt(); if_req = 0; #1;
    nxt(); if_flush = 1; #1;
    nxt(); if_flush = 0; #1;
    chk("fl2_ifv", if_valid, 0);      chk("fl2_ifd", if_data, rom(32'h28));

    // Reset in the middle of an LS access
    nxt(); ls_req = 1; ls_addr = 32'h50; #1;
    chk("rm_rdy", ls_ready, 1);
    nxt(); ls_req = 0; #1;
    nxt(); rst = 0; #1;
    chk("rm_ce", mem_ce, 0);          chk("rm_busy", busy, 0);
    chk("rm_addr", mem_addr, 0);      chk("rm_lsd", ls_data, 0);
    chk("rm_ifd", if_data, 0);        chk("rm_lsv", ls_valid, 0);
    nxt();
    nxt(); rst = 1;
    for (int k = 0; k < 3; k++) begin
      nxt(); #1;
      chk($sformatf("rm_lsv_post%0d", k), ls_valid, 0);
    end
    if_req = 1; if_addr = 32'h60; #1;
    chk("rm_ifrdy", if_ready, 1);
    nxt(); if_req = 0; #1;
    nxt(); #1;
    nxt(); #1;
    chk("rm_ifv", if_valid, 1);       chk("rm_ifd2", if_data, rom(32'h60));

    // Zero wait states: back-to-back IF at 0x0, 0x4, 0x8
    nxt(); if_req0 = 1; if_addr0 = 32'h0; #1;
    chk("w0_rdy_c0", if_ready0, 1);
    nxt(); if_addr0 = 32'h4; #1;
    chk("w0_rdy_c1", if_ready0, 0);   chk("w0_ce_c1", mem_ce0, 1);
    chk("w0_addr_c1", mem_addr0, 32'h0);
    nxt(); #1;
    chk("w0_rdy_c2", if_ready0, 1);   chk("w0_v_c2", if_valid0, 1);
    chk("w0_d_c2", if_data0, rom(32'h0)); chk("w0_ce_c2", mem_ce0, 0);
    nxt(); if_addr0 = 32'h8; #1;
    chk("w0_rdy_c3", if_ready0, 0);   chk("w0_v_c3", if_valid0, 0);
    nxt(); #1;
    chk("w0_rdy_c4", if_ready0, 1);   chk("w0_v_c4", if_valid0, 1);
    chk("w0_d_c4", if_data0, rom(32'h4));
    nxt(); if_req0 = 0; #1;
    nxt(); #1;
    chk("w0_v_c6", if_valid0, 1);     chk("w0_d_c6", if_data0, rom(32'h8));
    chk("w0_lsv", ls_valid0, 0);
    nxt(); #1;
    chk("w0_v_c7", if_valid0, 0);     chk("w0_busy_c7", busy0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Bound on total runtime in case the sequence stalls.
  initial begin
    #20000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end
endmodule
